rx_word_fifo: RTL and testbench
===============================

# rx_word_fifo

Receive-side word buffer directly downstream of the serial receive FSM in the full-duplex serial module. It captures each completed `receive_data` word on the receiver's end-of-word pulse and stores it in a small circular FIFO. The stored words are presented on a valid/ready interface. The block also drives the receiver's `state_in` start request, so a new receive is only launched while the FIFO has room.

## Interface

Parameters:
- `DATA_WIDTH_BASE`, default 5: word width W = 2**DATA_WIDTH_BASE (32 bits); must match the receive FSM.
- `DEPTH_LOG2`, default 2: FIFO depth D = 2**DEPTH_LOG2 (4 entries).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_en`  in  1  software enable for launching receives.
- `receive_data`  in  W  word from the receive FSM; stable while `finish_fsm` is high.
- `finish_fsm`  in  1  end-of-word pulse from the receive FSM.
- `state_req`  out  2  drives the receive FSM `state_in`: 2'd1 = start/continue receiving, 2'd0 = hold idle.
- `dout`  out  W  head-of-FIFO word.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer accepts `dout`.
- `count`  out  DEPTH_LOG2+1  current fill level, 0..D.
- `full`  out  1  count == D.
- `overflow`  out  1  sticky; set on a write while full.
- `ovf_cnt`  out  8  saturating count of overflow events.

## Operation

- Edge detect: `finish_fsm` is registered into `fin_d`. A write occurs when `finish_fsm & ~fin_d`, so one write per pulse even if the pulse is held for several cycles.
- Write: `receive_data` is stored at `mem[wr_ptr]` and `wr_ptr` increments.
- Read: a pop occurs when `dout_valid & dout_ready`. `rd_ptr` increments.
- `dout = mem[rd_ptr]` (combinational read). `dout_valid = (count != 0)`.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo D naturally.
- Count update: +1 on write only, -1 on pop only, unchanged on write+pop.
- Full with simultaneous write and pop: the pop frees the slot and the write is accepted. No overflow is flagged.
- Empty with write: there is no bypass. The word is visible the next cycle. A pop request while empty is ignored.
- Write while full without pop is an overflow event:
  - `overflow` is set and `ovf_cnt` increments, saturating at 255.
  - Data handling depends on the Configuration macro.
- `state_req = (rx_en && count < D) ? 2'd1 : 2'd0`, computed combinationally and forced to 2'd0 while `rst` is low.
  - The receive FSM samples `state_in` only in IDLE, and `count` updates one cycle after `finish_fsm` rises, before the FSM returns to IDLE.
  - At most one word is therefore in flight, so overflow cannot occur when `state_req` is honoured.
- `overflow` and `ovf_cnt` clear only on reset.

## Timing

- Reset values:
  - `count`, pointers, `fin_d`, `overflow`, `ovf_cnt` = 0.
  - `dout_valid` = 0, `full` = 0, `state_req` = 2'd0.
  - `mem` contents are not reset, so `dout` is undefined until the first write.
- Write latency: `finish_fsm` rises in cycle N; the word is in `mem` and `count` is updated at the edge ending N; `dout_valid` goes high in N+1.
- Pop: `dout_ready` is sampled at the edge. The next entry, or `dout_valid` = 0, appears in the following cycle.
- `state_req` drops in the same cycle `count` reaches D, and rises in the cycle after a pop from full.
- Reset asserted mid-operation:
  - All state clears immediately and stored words are discarded.
  - `state_req` = 0, so the receive FSM is not restarted.
  - A word completed during reset is not captured.

## Configuration

- `RX_FIFO_DROP_OLDEST_EN` defined:
  - An overflow write overwrites the oldest entry at `mem[rd_ptr]` with the new word.
  - Both `wr_ptr` and `rd_ptr` advance. `count` stays at D.
- Not defined (default):
  - An overflow write is discarded. The FIFO contents and pointers are unchanged.
- In both builds the overflow write sets `overflow` and increments `ovf_cnt`.

## Test plan

- Reset, `rx_en`=1, `dout_ready`=0; push 0xA5A5_0001..0xA5A5_0004 -> `count` steps 1..4, `full`=1, and `state_req` goes 2'd1 to 2'd0 in the cycle `count` becomes 4.
- With the FIFO full, set `dout_ready`=1 for 4 cycles -> `dout` = 0xA5A5_0001..0004 in order, then `dout_valid`=0 and `count`=0; `state_req`=1 the cycle after the first pop.
- Hold `finish_fsm` high for 5 cycles with `receive_data`=0x1234_5678 -> exactly one write, `count`=1.
- With the FIFO full, pulse `finish_fsm` with 0xDEAD_BEEF -> `overflow`=1, `ovf_cnt`=1, and:
  - default build: `dout` stays 0xA5A5_0001;
  - `RX_FIFO_DROP_OLDEST_EN` build: `dout` = 0xA5A5_0002 and the last entry read out is 0xDEAD_BEEF.
- With the FIFO full, write and pop in the same cycle -> `count` stays 4, `overflow` stays 0, and the new word is read out last. Then assert `rst` mid-burst -> `count`=0, `dout_valid`=0, `state_req`=0, `ovf_cnt`=0.
- Generate 300 forced overflow writes -> `ovf_cnt` saturates at 255.

Source files
------------

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: receive-side word buffer behind the serial receive FSM.
// It captures each completed receive_data word on the rising edge of
// finish_fsm and stores it in a circular FIFO of 2**DEPTH_LOG2 words.
// The words are presented on a valid/ready interface. The block also
// requests a new receive (state_req) only while the FIFO has room.
//
// Ports:
//   clk, rst         clock (rising edge); asynchronous active-low reset
//   rx_en            software enable for launching receives
//   receive_data     word from the receive FSM (W = 2**DATA_WIDTH_BASE)
//   finish_fsm       end-of-word pulse from the receive FSM
//   state_req        receive FSM state_in: 2'd1 = receive, 2'd0 = idle
//   dout, dout_valid head-of-FIFO word and FIFO-not-empty flag
//   dout_ready       consumer accepts dout
//   count, full      fill level 0..D, and count == D
//   overflow         sticky flag, set by a write while full
//   ovf_cnt          saturating count of overflow events
//
// Build option RX_FIFO_DROP_OLDEST_EN: an overflow write replaces the
// oldest word. When the option is off, an overflow write is discarded.
module rx_word_fifo #(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int DEPTH_LOG2      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_en,
  input  logic [(2**DATA_WIDTH_BASE)-1:0]   receive_data,
  input  logic                              finish_fsm,
  output logic [1:0]                        state_req,
  output logic [(2**DATA_WIDTH_BASE)-1:0]   dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [DEPTH_LOG2:0]               count,
  output logic                              full,
  output logic                              overflow,
  output logic [7:0]                        ovf_cnt
);

  localparam int unsigned W     = 2**DATA_WIDTH_BASE;
  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    REQ_IDLE    = 2'd0,
    REQ_RECEIVE = 2'd1
  } req_e;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  fin_d;

  logic wr_evt;
  logic pop;
  logic ovf_evt;
  logic wr_accept;
  logic rd_adv;
  logic cnt_up;
  logic cnt_dn;
  req_e req;

  assign full       = (count == FULL_COUNT);
  assign dout_valid = (count != '0);
  assign dout       = mem[rd_ptr];

  // One write per finish_fsm pulse, however long the pulse is held.
  assign wr_evt  = finish_fsm & ~fin_d;
  assign pop     = dout_valid & dout_ready;
  assign ovf_evt = wr_evt & full & ~pop;

`ifdef RX_FIFO_DROP_OLDEST_EN
  // When the FIFO is full, wr_ptr equals rd_ptr. Writing at wr_ptr therefore
  // overwrites the oldest word. Advancing both pointers keeps count at D.
  assign wr_accept = wr_evt;
  assign rd_adv    = pop | ovf_evt;
`else
  assign wr_accept = wr_evt & (~full | pop);
  assign rd_adv    = pop;
`endif

  // The fill level is unchanged by a write and a pop in the same cycle, and
  // by an overflow write in either build.
  assign cnt_up = wr_evt & ~pop & ~full;
  assign cnt_dn = pop & ~wr_evt;

  always_comb begin
    req = REQ_IDLE;
    if (rst && rx_en && !full) begin
      req = REQ_RECEIVE;
    end
  end

  assign state_req = req;

  // The storage has no reset. The rst term stops a word that finishes while
  // the block is held in reset from being captured.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[wr_ptr] <= receive_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_d    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      fin_d <= finish_fsm;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cnt_up) begin
        count <= count + 1'b1;
      end else if (cnt_dn) begin
        count <= count - 1'b1;
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
        if (ovf_cnt != '1) begin
          ovf_cnt <= ovf_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_word_fifo.sv
module tb_rx_word_fifo;

  logic        clk;
  logic        rst;
  logic        rx_en;
  logic [31:0] receive_data;
  logic        finish_fsm;
  logic [1:0]  state_req;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  ovf_cnt;

  rx_word_fifo #(.DATA_WIDTH_BASE(5), .DEPTH_LOG2(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_en        (rx_en),
    .receive_data (receive_data),
    .finish_fsm   (finish_fsm),
    .state_req    (state_req),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .ovf_cnt      (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the words queued for the consumer plus the flag state.
  logic [31:0] sb [$];
  logic        m_fin_d;
  logic        m_ovf;
  int          m_ovf_cnt;

  typedef struct {
    logic        en;
    logic        fin;
    logic [31:0] d;
    logic        rdy;
    int          e_cnt;
    logic        e_valid;
    logic [1:0]  e_req;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_fin_d   = 1'b0;
    m_ovf     = 1'b0;
    m_ovf_cnt = 0;
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(sb.size()));
    chk("dout_valid", 32'(dout_valid), 32'(sb.size() != 0));
    chk("full", 32'(full), 32'(sb.size() == 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf_cnt));
    chk("state_req", 32'(state_req), (rx_en && sb.size() < 4) ? 32'd1 : 32'd0);
  endtask

  // Called at posedge+1. Drives the inputs for one cycle. Scores any pop
  // against the queue, then advances the model across the edge and checks.
  task automatic cycle(input logic en, input logic fin, input logic [31:0] d, input logic rdy);
    logic        full_pre;
    logic        do_pop;
    logic        wr;
    logic [31:0] exp_w;
    logic [31:0] junk;
    rx_en        = en;
    finish_fsm   = fin;
    receive_data = d;
    dout_ready   = rdy;
    #1;
    full_pre = (sb.size() == 4);
    do_pop   = rdy && (sb.size() != 0);
    wr       = fin && !m_fin_d;
    if (do_pop) begin
      exp_w = sb.pop_front();
      chk("dout_pop", dout, exp_w);
    end
    @(posedge clk);
    #1;
    m_fin_d = fin;
    if (wr) begin
      if (!full_pre || do_pop) begin
        sb.push_back(d);
      end else begin
        m_ovf = 1'b1;
        if (m_ovf_cnt < 255) m_ovf_cnt++;
`ifdef RX_FIFO_DROP_OLDEST_EN
        junk = sb.pop_front();
        sb.push_back(d);
`else
        junk = d;
`endif
      end
    end
    check_model();
  endtask

  task automatic push_word(input logic [31:0] d);
    cycle(1'b1, 1'b1, d, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Asserts reset at posedge+1 and holds it for two edges. A finish_fsm pulse
  // is applied while reset is held and must not be captured.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_state_req", 32'(state_req), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    finish_fsm   = 1'b1;
    receive_data = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    finish_fsm = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_model();
  endtask

  task automatic add(input logic en, input logic fin, input logic [31:0] d, input logic rdy,
                     input int cnt, input logic valid, input logic [1:0] req);
    vec_t v;
    v.en = en; v.fin = fin; v.d = d; v.rdy = rdy;
    v.e_cnt = cnt; v.e_valid = valid; v.e_req = req;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rx_en = 1'b1; finish_fsm = 1'b0; receive_data = '0; dout_ready = 1'b0;
    model_reset();

    // Fill to full with ready low, then drain, then a held finish pulse.
    add(1, 1, 32'hA5A5_0001, 0, 1, 1, 2'd1);
    add(1, 0, 32'h0,         0, 1, 1, 2'd1);
    add(1, 1, 32'hA5A5_0002, 0, 2, 1, 2'd1);
    add(1, 0, 32'h0,         0, 2, 1, 2'd1);
    add(1, 1, 32'hA5A5_0003, 0, 3, 1, 2'd1);
    add(1, 0, 32'h0,         0, 3, 1, 2'd1);
    add(1, 1, 32'hA5A5_0004, 0, 4, 1, 2'd0);
    add(1, 0, 32'h0,         0, 4, 1, 2'd0);
    add(1, 0, 32'h0,         1, 3, 1, 2'd1);
    add(1, 0, 32'h0,         1, 2, 1, 2'd1);
    add(1, 0, 32'h0,         1, 1, 1, 2'd1);
    add(1, 0, 32'h0,         1, 0, 0, 2'd1);
    add(1, 0, 32'h0,         1, 0, 0, 2'd1);
    for (int i = 0; i < 5; i++) add(1, 1, 32'h1234_5678, 0, 1, 1, 2'd1);
    add(1, 0, 32'h0,         0, 1, 1, 2'd1);
    add(1, 0, 32'h0,         1, 0, 0, 2'd1);
    add(0, 0, 32'h0,         0, 0, 0, 2'd0);

    @(posedge clk);
    #1;
    do_reset();

    foreach (vt[i]) begin
      cycle(vt[i].en, vt[i].fin, vt[i].d, vt[i].rdy);
      chk("tbl_count", 32'(count), 32'(vt[i].e_cnt));
      chk("tbl_valid", 32'(dout_valid), 32'(vt[i].e_valid));
      chk("tbl_state_req", 32'(state_req), 32'(vt[i].e_req));
    end

    // Overflow while full, without a pop.
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(32'hA5A5_0000 + 32'(i));
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
`ifdef RX_FIFO_DROP_OLDEST_EN
    chk("ovf_head", dout, 32'hA5A5_0002);
`else
    chk("ovf_head", dout, 32'hA5A5_0001);
`endif
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("ovf_drained", 32'(sb.size()), 32'd0);

    // Write and pop in the same cycle while full.
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(32'h0000_0010 + 32'(i));
    cycle(1'b1, 1'b1, 32'h0000_0055, 1'b1);
    chk("wp_count", 32'(count), 32'd4);
    chk("wp_overflow", 32'(overflow), 32'd0);
    chk("wp_head", dout, 32'h0000_0012);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wp_tail", sb[sb.size()-1], 32'h0000_0055);
    // Reset in the middle of a burst.
    do_reset();
    chk("mid_rst_count", 32'(count), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Forced overflows until the counter saturates.
    for (int i = 1; i <= 4; i++) push_word(32'h0000_0100 + 32'(i));
    for (int i = 0; i < 300; i++) push_word(32'h7700_0000 + 32'(i));
    chk("ovf_saturate", 32'(ovf_cnt), 32'd255);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("sat_empty", 32'(dout_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
